// File: rtl/seg2_decode.sv
// Recovers a byte from a two-digit multiplexed 7-segment scan (active-low digit
// select and segments), publishing it when a low digit is followed by a high digit.
module seg2_decode #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig,
    input  logic [7:0] segments,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       changed,
    output logic       code_err,
    output logic       locked
);

    localparam logic [15:0] TO = 16'(TIMEOUT);

    typedef enum logic {
        IDLE,
        GOT_LO
    } state_t;

    state_t      state, state_next;
    logic [3:0]  dig_q;
    logic [7:0]  seg_q;
    logic [3:0]  lo_buf;
    logic [15:0] cnt;
    logic [3:0]  nib;
    logic        seg_legal;
    logic        publish;
    logic        err;
    logic        lo_load;
    logic [7:0]  new_byte;
    logic        timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_q <= 4'b1111;
            seg_q <= 8'hff;
        end else begin
            dig_q <= dig;
            seg_q <= segments;
        end
    end

    always_comb begin
        seg_legal = 1'b1;
        nib       = 4'h0;
        case (seg_q)
            8'hc0: nib = 4'h0;
            8'hf9: nib = 4'h1;
            8'ha4: nib = 4'h2;
            8'hb0: nib = 4'h3;
            8'h99: nib = 4'h4;
            8'h92: nib = 4'h5;
            8'h82: nib = 4'h6;
            8'hf8: nib = 4'h7;
            8'h80: nib = 4'h8;
            8'h90: nib = 4'h9;
            8'h88: nib = 4'hA;
            8'h83: nib = 4'hB;
            8'hc6: nib = 4'hC;
            8'ha1: nib = 4'hD;
            8'h86: nib = 4'hE;
            8'h8e: nib = 4'hF;
            default: seg_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A high digit with no pending low digit is ignored outright, segments unchecked.
    always_comb begin
        state_next = state;
        publish    = 1'b0;
        err        = 1'b0;
        lo_load    = 1'b0;
        case (dig_q)
            4'b1111: ;
            4'b1110: begin
                if (seg_legal) begin
                    lo_load    = 1'b1;
                    state_next = GOT_LO;
                end else begin
                    err        = 1'b1;
                    state_next = IDLE;
                end
            end
            4'b1101: begin
                if (state == GOT_LO) begin
                    publish    = seg_legal;
                    err        = !seg_legal;
                    state_next = IDLE;
                end
            end
            default: begin
                err        = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        new_byte    = {nib, lo_buf};
        timeout_hit = (cnt >= TO - 16'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            changed    <= 1'b0;
            code_err   <= 1'b0;
            locked     <= 1'b0;
            lo_buf     <= '0;
            cnt        <= '0;
        end else begin
            data_valid <= publish;
            changed    <= publish && (new_byte != data);
            code_err   <= err;
            if (lo_load) lo_buf <= nib;
            if (publish) begin
                data   <= new_byte;
                locked <= 1'b1;
                cnt    <= '0;
            end else begin
                if (cnt != TO) cnt <= cnt + 16'd1;
                if (err || timeout_hit) locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg2_decode.sv
// Self-checking bench for seg2_decode: directed table, hand sequences for reset and
// timeout corners, and a randomized run against a frame-level reference model.
module tb_seg2_decode;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dig = 4'b1111;
    logic [7:0] segments = 8'hff;
    logic [7:0] data;
    logic       data_valid, changed, code_err, locked;

    int checks = 0;
    int errors = 0;

    seg2_decode #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .dig(dig), .segments(segments),
        .data(data), .data_valid(data_valid), .changed(changed),
        .code_err(code_err), .locked(locked)
    );

    always #5 clk = ~clk;

    logic [7:0] codes [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

    // Reference model: digit-pair protocol evaluated on the sample taken one edge earlier.
    bit         m_have_lo;
    logic [3:0] m_lo;
    logic [7:0] m_data;
    bit         m_dv, m_ch, m_ce, m_locked;
    int         m_cnt;
    logic [3:0] prev_d;
    logic [7:0] prev_s;

    function automatic int decode(input logic [7:0] s);
        for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_have_lo = 0; m_lo = 0; m_data = 0; m_dv = 0; m_ch = 0; m_ce = 0;
        m_locked = 0; m_cnt = 0; prev_d = 4'b1111; prev_s = 8'hff;
    endtask

    task automatic model_step(input logic [3:0] d, input logic [7:0] s);
        int n;
        bit pub;
        n = decode(s);
        pub = 0;
        m_dv = 0; m_ch = 0; m_ce = 0;
        if (d == 4'b1110) begin
            if (n >= 0) begin m_have_lo = 1; m_lo = 4'(n); end
            else m_ce = 1;
        end else if (d == 4'b1101) begin
            if (m_have_lo) begin
                if (n >= 0) pub = 1;
                else m_ce = 1;
            end
        end else if (d != 4'b1111) begin
            m_ce = 1;
        end
        if (m_ce) begin m_have_lo = 0; m_locked = 0; end
        if (pub) begin
            m_ch = ({4'(n), m_lo} != m_data);
            m_data = {4'(n), m_lo};
            m_dv = 1; m_locked = 1; m_cnt = 0; m_have_lo = 0;
        end else begin
            if (m_cnt < TO) m_cnt++;
            if (m_cnt >= TO) m_locked = 0;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] d, input bit dv,
                           input bit ch, input bit ce, input bit lk);
        chk({name, ".data"}, data, d);
        chk({name, ".data_valid"}, {7'd0, data_valid}, {7'd0, dv});
        chk({name, ".changed"}, {7'd0, changed}, {7'd0, ch});
        chk({name, ".code_err"}, {7'd0, code_err}, {7'd0, ce});
        chk({name, ".locked"}, {7'd0, locked}, {7'd0, lk});
    endtask

    task automatic tick(input logic [3:0] d, input logic [7:0] s);
        dig = d; segments = s;
        @(posedge clk); #1;
        model_step(prev_d, prev_s);
        prev_d = d; prev_s = s;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; dig = 4'b1111; segments = 8'h00;
        #1;
        chk_all("async_reset", 8'h00, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("in_reset", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        rst = 0; dig = 4'b1111; segments = 8'hff;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] d;
        logic [7:0] s;
        logic [7:0] e_data;
        bit e_dv, e_ch, e_ce, e_lk;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [3:0] rd;
        logic [7:0] rs;
        model_reset();
        // Expected columns show outputs after the edge that applies the row, i.e. the
        // effect of the previous row's inputs.
        vecs[0] = '{4'b1110, 8'h88, 8'h00, 0, 0, 0, 0};
        vecs[1] = '{4'b1101, 8'hb0, 8'h00, 0, 0, 0, 0};
        vecs[2] = '{4'b1111, 8'hff, 8'h3A, 1, 1, 0, 1};
        vecs[3] = '{4'b1110, 8'h88, 8'h3A, 0, 0, 0, 1};
        vecs[4] = '{4'b1101, 8'hb0, 8'h3A, 0, 0, 0, 1};
        vecs[5] = '{4'b1111, 8'hff, 8'h3A, 1, 0, 0, 1};
        vecs[6] = '{4'b1110, 8'hff, 8'h3A, 0, 0, 0, 1};
        vecs[7] = '{4'b1111, 8'hff, 8'h3A, 0, 0, 1, 0};
        vecs[8] = '{4'b1111, 8'hff, 8'h3A, 0, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(vecs[i].d, vecs[i].s);
            chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_dv,
                    vecs[i].e_ch, vecs[i].e_ce, vecs[i].e_lk);
        end

        // Lone high digit is ignored, then a proper frame publishes 0x10.
        do_reset();
        tick(4'b1101, 8'hf9);
        tick(4'b1111, 8'h5a);
        chk_all("hi_alone", 8'h00, 0, 0, 0, 0);
        tick(4'b1110, 8'hc0);
        chk_all("hi_alone2", 8'h00, 0, 0, 0, 0);
        tick(4'b1101, 8'hf9);
        tick(4'b1111, 8'hff);
        chk_all("frame10", 8'h10, 1, 1, 0, 1);

        // Timeout: locked falls exactly TO edges after the publish edge.
        for (int k = 1; k <= TO + 2; k++) begin
            tick(4'b1111, 8'hff);
            chk($sformatf("timeout_k%0d", k), {7'd0, locked}, (k < TO) ? 8'd1 : 8'd0);
        end
        chk("timeout_data", data, 8'h10);

        // Reset while a low digit is pending discards it.
        tick(4'b1110, 8'h92);
        do_reset();
        tick(4'b1101, 8'h86);
        tick(4'b1111, 8'hff);
        chk_all("rst_got_lo", 8'h00, 0, 0, 0, 0);

        // Illegal digit select.
        tick(4'b1110, 8'h99);
        tick(4'b1011, 8'h99);
        tick(4'b1101, 8'h99);
        chk_all("bad_dig", 8'h00, 0, 0, 1, 0);
        tick(4'b1111, 8'hff);
        chk_all("bad_dig_after", 8'h00, 0, 0, 0, 0);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)       rd = 4'b1110;
            else if (r < 8)  rd = 4'b1101;
            else if (r == 8) rd = 4'b1111;
            else             rd = 4'($urandom);
            if ($urandom_range(0, 99) < 85) rs = codes[$urandom_range(0, 15)];
            else                            rs = 8'($urandom);
            if (i % 200 == 199) rd = 4'b1111;
            repeat (($urandom_range(0, 19) == 0) ? TO : 1) tick(rd, rs);
            chk_all("rand", m_data, m_dv, m_ch, m_ce, m_locked);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg2_decode.md
SEG2_DECODE -- requirements
Module: seg2_decode

Interface
REQ-001 Parameter TIMEOUT, default 1024, number of clock cycles without a completed frame before lock is dropped; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 dig  input  4  digit-select scan, active-low: 1110 = low digit, 1101 = high digit, 1111 = blank.
REQ-005 segments  input  8  active-low segment pattern {dp,g,f,e,d,c,b,a}; sampled in the same cycle as dig.
REQ-006 data  output  8  last reconstructed byte {high nibble, low nibble}; registered.
REQ-007 data_valid  output  1  one-cycle pulse when data is updated.
REQ-008 changed  output  1  one-cycle pulse, coincident with data_valid, when the new byte differs from the previous data value.
REQ-009 code_err  output  1  one-cycle pulse on an illegal dig or segments pattern.
REQ-010 locked  output  1  level; high while complete frames keep arriving within TIMEOUT cycles.

Function
REQ-011 dig and segments SHALL be registered once (dig_q, seg_q) before any decoding.
REQ-012 seg_q SHALL decode to a nibble only on an exact match: c0=0, f9=1, a4=2, b0=3, 99=4, 92=5, 82=6, f8=7, 80=8, 90=9, 88=A, 83=b, c6=C, a1=d, 86=E, 8e=F; all other values are illegal.
REQ-013 The FSM SHALL have two states, IDLE and GOT_LO, and SHALL enter IDLE on reset.
REQ-014 IDLE, dig_q=1110, legal code -> store the nibble in lo_buf; go to GOT_LO.
REQ-015 GOT_LO, dig_q=1110, legal code -> overwrite lo_buf; stay in GOT_LO.
REQ-016 GOT_LO, dig_q=1101, legal code -> data <= {nibble, lo_buf}; data_valid=1; changed=1 if the new byte differs from the old data; locked <= 1; timeout counter cleared; go to IDLE.
REQ-017 IDLE, dig_q=1101 -> ignore the cycle; no error; state and outputs unchanged.
REQ-018 dig_q=1111 in any state -> ignore the cycle; state and lo_buf held; segments not checked.
REQ-019 dig_q=1110 or 1101 with an illegal code, or dig_q not in {1110, 1101, 1111} -> code_err=1; locked <= 0; go to IDLE; data unchanged.
REQ-020 Latency: a high-digit pattern present on the inputs at edge N SHALL produce data/data_valid visible after edge N+1.
REQ-021 The 16-bit timeout counter SHALL increment every cycle without a publish and saturate at TIMEOUT; on reaching TIMEOUT, locked <= 0; data is held.
REQ-022 A publish and a timeout in the same cycle: the publish wins (locked=1, counter=0).
REQ-023 data_valid, changed and code_err SHALL be low in every cycle not listed above.
REQ-024 The reconstructed byte SHALL wrap naturally (8 bits); no other arithmetic is performed.

Reset
REQ-025 On rst high, immediately and independent of clk: data=00, data_valid=0, changed=0, code_err=0, locked=0, state=IDLE, lo_buf=0, dig_q=1111, seg_q=ff, timeout counter=0.
REQ-026 Reset asserted in GOT_LO SHALL discard lo_buf; a following high digit alone SHALL NOT publish.
REQ-027 While rst is high, the input values (including dig=1111, segments=00) SHALL have no effect.

Verification
REQ-028 After reset, drive (1110,88) then (1101,b0) -> data=3A, data_valid and changed pulse once, locked=1, two edges after the high digit.
REQ-029 Repeat the 3A scan -> data_valid pulses, changed stays 0, data=3A.
REQ-030 Drive (1110,ff) -> code_err pulses, locked=0, no data_valid, data holds 3A.
REQ-031 After reset, drive (1101,f9) then (1111,xx) -> no pulses; then (1110,c0),(1101,f9) -> data=10.
REQ-032 TIMEOUT=16: publish once, then hold dig=1111 -> locked falls exactly 16 cycles after the publish; data held.
REQ-033 Drive (1110,92), pulse rst, then (1101,86) -> no data_valid; data=00, locked=0.
